const_pattern_gen: RTL and testbench
====================================

# const_pattern_gen

Parametrised successor to the fixed-constant sources: a programmable constant/pattern source with a DEPTH-entry register file. It drives a WIDTH-bit value that can be a held constant, a one-shot or looping sequence of stored entries, or a free-running count. Each value is held for a programmable number of cycles. It feeds datapath test inputs and LED/display stimulus where a hard-wired constant is no longer enough.

## Interface
Parameters:
- WIDTH, 4, output and entry width
- DEPTH, 8, register-file entries (power of two, ≥2); AW = $clog2(DEPTH)
- RESET_VALUE, 4'b0111 (WIDTH bits), reset value of every entry and of out
- DIV_W, 16, width of the hold-cycle divider

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe to register file
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- mode  in  2  0 CONST, 1 SEQ_ONCE, 2 SEQ_LOOP, 3 COUNT; sampled at start
- len  in  AW  index of last sequence entry; sampled at start
- div  in  DIV_W  hold cycles minus one per value; sampled at start
- start  in  1  begin pattern (honoured only in IDLE)
- stop  in  1  abort to IDLE
- out  out  WIDTH  registered pattern value
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at SEQ_ONCE completion
- wrap  out  1  one-cycle pulse on sequence/count wrap

## Operation
- Reset (rst_n=0 at a clk edge): all entries = RESET_VALUE, out = RESET_VALUE, busy = done = wrap = 0, idx = cnt = 0, state IDLE. Writes are ignored while rst_n=0.
- Register file: synchronous write, asynchronous read. Writes are accepted in any state. A write to an entry is seen at the next read of that entry.
- States: IDLE, RUN.
- IDLE:
  - out holds its last value.
  - start & !stop → RUN; mode_q/len_q/div_q latched; idx=0; cnt=0; out=mem[0].
- RUN, CONST: out = mem[0] every cycle. Runs until stop.
- RUN, SEQ_*: cnt increments each cycle. When cnt==div_q: cnt=0 and idx advances.
  - SEQ_LOOP: idx==len_q → idx=0, out=mem[0], wrap=1; otherwise out=mem[idx+1].
  - SEQ_ONCE: idx==len_q → IDLE, done=1, out holds mem[len_q].
- RUN, COUNT: start loads out=mem[0]. out = out+1 mod 2^WIDTH every div_q+1 cycles. wrap=1 on the all-ones→0 step.
- stop in RUN → IDLE next cycle; out holds; no done, no wrap.
- start and stop together: stop wins.
- start while busy is ignored.
- Mode/len/div changes while busy have no effect.
- div=0: a new value every cycle.
- len=0: SEQ_LOOP holds mem[0] and pulses wrap every div_q+1 cycles.

## Timing
- start sampled at edge T → out=mem[0], busy=1 after T.
- Each sequence value is held exactly div_q+1 cycles.
- done and wrap assert in the same cycle out takes the final or wrapped value. Each lasts one cycle.
- busy falls the cycle done rises.
- A new start is accepted the cycle after done.
- Reset mid-run takes effect at the next edge. Every output and entry returns to its reset value.
- No combinational path from inputs to outputs.

## Structure
- Package const_pattern_pkg: mode_t enum (MODE_CONST, MODE_SEQ_ONCE, MODE_SEQ_LOOP, MODE_COUNT) and state_t enum (ST_IDLE, ST_RUN).
- Sub-module pattern_regfile: DEPTH×WIDTH, sync write, async read, synchronous active-low reset to RESET_VALUE.
- Top holds the FSM, divider counter and index counter.

## Test plan
- Reset: defaults, no writes → out=4'b0111, busy=0. start in CONST → out stays 4'b0111. Write entry0=4'hA → out=4'hA one cycle later.
- SEQ_ONCE: entries 1,2,3, len=2, div=1 → out 1,1,2,2,3,3 from T+1. done pulses with the first 3, busy falls, out stays 3.
- SEQ_LOOP: len=1, div=0, entries 5,9 → out 5,9,5,9. wrap is high on every 5 after the first.
- COUNT: entry0=4'hE, div=0 → out E,F,0,1. wrap is high with 0.
- Stop and start collisions: stop mid-SEQ_LOOP → IDLE next cycle, out frozen, no done. start and stop together in IDLE → stays IDLE. start while busy → ignored, sequence unchanged.
- Reset and writes during RUN: rst_n low mid-COUNT → out=4'b0111, busy=0, all entries back to 4'b0111. Write entry2 during SEQ_LOOP → the new value appears at the next visit to entry2.

Source files
------------

// File: rtl/const_pattern_pkg.sv
// const_pattern_pkg: shared mode and state encodings for const_pattern_gen
package const_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_CONST    = 2'd0,
        MODE_SEQ_ONCE = 2'd1,
        MODE_SEQ_LOOP = 2'd2,
        MODE_COUNT    = 2'd3
    } mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pattern_regfile.sv
// pattern_regfile: DEPTH x WIDTH entry store, synchronous write, asynchronous read
//   i_clk, i_rst_n            : clock, synchronous active-low reset (entries -> RESET_VALUE)
//   i_wr_en/i_wr_addr/i_wr_data : write port, ignored while in reset
//   i_rd_addr -> o_rd_data    : combinational read port
module pattern_regfile #(
    parameter int               WIDTH       = 4,
    parameter int               DEPTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = 4'b0111,
    localparam int              AW          = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VALUE;
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/const_pattern_gen.sv
// const_pattern_gen: programmable constant / sequence / counter source with per-value hold divider
//   i_clk, i_rst_n                 : clock, synchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_data    : register-file write port, accepted in any state
//   i_mode/i_len/i_div             : pattern setup, latched when a start is accepted
//   i_start/i_stop                 : begin pattern from IDLE / abort to IDLE (stop wins)
//   o_out                          : registered pattern value
//   o_busy/o_done/o_wrap           : running flag, SEQ_ONCE completion pulse, wrap pulse
module const_pattern_gen
    import const_pattern_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               DEPTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = 4'b0111,
    parameter int               DIV_W       = 16,
    localparam int              AW          = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [1:0]       i_mode,
    input  logic [AW-1:0]    i_len,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_wrap
);

    state_t           r_state, w_nxt_state;
    mode_t            r_mode, w_nxt_mode;
    logic [AW-1:0]    r_len, w_nxt_len;
    logic [DIV_W-1:0] r_div, w_nxt_div;
    logic [AW-1:0]    r_idx, w_nxt_idx;
    logic [DIV_W-1:0] r_cnt, w_nxt_cnt;
    logic [WIDTH-1:0] r_out, w_nxt_out;
    logic             r_done, w_nxt_done;
    logic             r_wrap, w_nxt_wrap;

    logic             w_tick;
    logic             w_last;
    logic             w_seq;
    logic [AW-1:0]    w_idx_inc;
    logic [AW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_rd_data;

    assign w_tick    = r_cnt == r_div;
    assign w_last    = r_idx == r_len;
    assign w_idx_inc = r_idx + AW'(1);
    assign w_seq     = r_mode == MODE_SEQ_ONCE || r_mode == MODE_SEQ_LOOP;
    // Read the entry that becomes visible on the next advance; entry 0 otherwise
    // (start, CONST, and the loop wrap all load entry 0).
    assign w_rd_addr = (r_state == ST_RUN && w_seq && !w_last) ? w_idx_inc : '0;

    pattern_regfile #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_regfile (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_CONST;
            r_len   <= '0;
            r_div   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_out   <= RESET_VALUE;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_mode  <= w_nxt_mode;
            r_len   <= w_nxt_len;
            r_div   <= w_nxt_div;
            r_idx   <= w_nxt_idx;
            r_cnt   <= w_nxt_cnt;
            r_out   <= w_nxt_out;
            r_done  <= w_nxt_done;
            r_wrap  <= w_nxt_wrap;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_mode  = r_mode;
        w_nxt_len   = r_len;
        w_nxt_div   = r_div;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt;
        w_nxt_out   = r_out;
        w_nxt_done  = 1'b0;
        w_nxt_wrap  = 1'b0;
        if (r_state == ST_IDLE) begin
            if (i_start && !i_stop) begin
                w_nxt_state = ST_RUN;
                w_nxt_mode  = mode_t'(i_mode);
                w_nxt_len   = i_len;
                w_nxt_div   = i_div;
                w_nxt_idx   = '0;
                w_nxt_cnt   = '0;
                w_nxt_out   = w_rd_data;
            end
        end else if (i_stop) begin
            w_nxt_state = ST_IDLE;
        end else if (r_mode == MODE_CONST) begin
            w_nxt_out = w_rd_data;
        end else begin
            w_nxt_cnt = w_tick ? '0 : r_cnt + DIV_W'(1);
            if (w_tick && r_mode == MODE_COUNT) begin
                w_nxt_out  = r_out + WIDTH'(1);
                w_nxt_wrap = &r_out;
            end else if (w_tick && r_mode == MODE_SEQ_LOOP) begin
                w_nxt_idx  = w_last ? '0 : w_idx_inc;
                w_nxt_out  = w_rd_data;
                w_nxt_wrap = w_last;
            end else if (w_tick) begin
                // One-shot finishes as the final entry is loaded; len=0 has nothing
                // left to load, so it finishes on its first tick holding entry 0.
                w_nxt_idx   = w_last ? r_idx : w_idx_inc;
                w_nxt_out   = w_last ? r_out : w_rd_data;
                w_nxt_done  = w_last || w_idx_inc == r_len;
                w_nxt_state = w_nxt_done ? ST_IDLE : ST_RUN;
            end
        end
    end

    assign o_out  = r_out;
    assign o_busy = r_state == ST_RUN;
    assign o_done = r_done;
    assign o_wrap = r_wrap;

endmodule

// File: tb/tb_const_pattern_gen.sv
// tb_const_pattern_gen: directed scoreboard bench; each cycle queues the expected {out,busy,done,wrap}
module tb_const_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [3:0]  wr_data = '0;
    logic [1:0]  mode = '0;
    logic [2:0]  len = '0;
    logic [15:0] div = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  out;
    logic        busy, done, wrap;

    logic [6:0]  exp_q [$];
    int          checks = 0;
    int          failures = 0;
    int          step = 0;

    const_pattern_gen dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_mode    (mode),
        .i_len     (len),
        .i_div     (div),
        .i_start   (start),
        .i_stop    (stop),
        .o_out     (out),
        .o_busy    (busy),
        .o_done    (done),
        .o_wrap    (wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [6:0] e;
            e = exp_q.pop_front();
            step++;
            checks++;
            if ({out, busy, done, wrap} !== e) begin
                failures++;
                $display("FAIL step%0d out/busy/done/wrap got=%h/%b/%b/%b exp=%h/%b/%b/%b",
                         step, out, busy, done, wrap, e[6:3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic cyc(input logic [3:0] o, input logic b, input logic d, input logic w);
        exp_q.push_back({o, b, d, w});
        @(posedge clk);
        #2;
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] v);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = v;
    endtask

    task automatic go(input logic [1:0] m, input logic [2:0] l, input logic [15:0] dv);
        mode  = m;
        len   = l;
        div   = dv;
        start = 1'b1;
    endtask

    initial begin
        cyc(4'h7, 0, 0, 0);
        cyc(4'h7, 0, 0, 0);
        rst_n = 1'b1;
        cyc(4'h7, 0, 0, 0);
        // CONST from reset contents, then a live write to entry 0
        go(2'd0, 3'd0, 16'd0);
        cyc(4'h7, 1, 0, 0);
        cyc(4'h7, 1, 0, 0);
        wr(3'd0, 4'hA);
        cyc(4'h7, 1, 0, 0);
        cyc(4'hA, 1, 0, 0);
        stop = 1'b1;
        cyc(4'hA, 0, 0, 0);
        cyc(4'hA, 0, 0, 0);
        // SEQ_ONCE 1,2,3 with div=1
        wr(3'd0, 4'h1); cyc(4'hA, 0, 0, 0);
        wr(3'd1, 4'h2); cyc(4'hA, 0, 0, 0);
        wr(3'd2, 4'h3); cyc(4'hA, 0, 0, 0);
        go(2'd1, 3'd2, 16'd1);
        cyc(4'h1, 1, 0, 0);
        cyc(4'h1, 1, 0, 0);
        cyc(4'h2, 1, 0, 0);
        cyc(4'h2, 1, 0, 0);
        cyc(4'h3, 0, 1, 0);
        // restart immediately after done, then abort
        go(2'd1, 3'd2, 16'd1);
        cyc(4'h1, 1, 0, 0);
        stop = 1'b1;
        cyc(4'h1, 0, 0, 0);
        // SEQ_LOOP 5,9 with div=0; start while busy is ignored; stop freezes
        wr(3'd0, 4'h5); cyc(4'h1, 0, 0, 0);
        wr(3'd1, 4'h9); cyc(4'h1, 0, 0, 0);
        go(2'd2, 3'd1, 16'd0);
        cyc(4'h5, 1, 0, 0);
        cyc(4'h9, 1, 0, 0);
        cyc(4'h5, 1, 0, 1);
        cyc(4'h9, 1, 0, 0);
        go(2'd3, 3'd0, 16'd3);
        cyc(4'h5, 1, 0, 1);
        cyc(4'h9, 1, 0, 0);
        stop = 1'b1;
        cyc(4'h9, 0, 0, 0);
        cyc(4'h9, 0, 0, 0);
        go(2'd2, 3'd1, 16'd0);
        stop = 1'b1;
        cyc(4'h9, 0, 0, 0);
        cyc(4'h9, 0, 0, 0);
        // SEQ_LOOP over 5,9,3 with entry 2 rewritten mid-run
        go(2'd2, 3'd2, 16'd0);
        cyc(4'h5, 1, 0, 0);
        cyc(4'h9, 1, 0, 0);
        cyc(4'h3, 1, 0, 0);
        wr(3'd2, 4'hC);
        cyc(4'h5, 1, 0, 1);
        cyc(4'h9, 1, 0, 0);
        cyc(4'hC, 1, 0, 0);
        cyc(4'h5, 1, 0, 1);
        stop = 1'b1;
        cyc(4'h5, 0, 0, 0);
        // len=0 loop holds entry 0, wrap every div+1 cycles
        go(2'd2, 3'd0, 16'd1);
        cyc(4'h5, 1, 0, 0);
        cyc(4'h5, 1, 0, 0);
        cyc(4'h5, 1, 0, 1);
        cyc(4'h5, 1, 0, 0);
        cyc(4'h5, 1, 0, 1);
        stop = 1'b1;
        cyc(4'h5, 0, 0, 0);
        // COUNT from E with wrap on F->0, then reset mid-run (write during reset ignored)
        wr(3'd0, 4'hE); cyc(4'h5, 0, 0, 0);
        go(2'd3, 3'd0, 16'd0);
        cyc(4'hE, 1, 0, 0);
        cyc(4'hF, 1, 0, 0);
        cyc(4'h0, 1, 0, 1);
        cyc(4'h1, 1, 0, 0);
        rst_n = 1'b0;
        wr(3'd0, 4'hA);
        cyc(4'h7, 0, 0, 0);
        rst_n = 1'b1;
        // walk all eight entries: every one back at the reset value
        go(2'd2, 3'd7, 16'd0);
        for (int i = 0; i < 8; i++) cyc(4'h7, 1, 0, 0);
        cyc(4'h7, 1, 0, 1);
        stop = 1'b1;
        cyc(4'h7, 0, 0, 0);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
